sqroot_seq: RTL

Parametrised, iterative integer square-root unit. It is the sequential successor to the 8-bit combinational sqroot_comb.
- Computes floor or round-to-nearest sqrt of an NBITS-wide unsigned operand.
- Produces one result bit per clock.
- Uses valid/ready handshakes on both sides.
- Sits in the arithmetic datapath where a wide combinational sqrt cannot meet timing.

---
 rtl/sqroot_pkg.sv | 29 ++
 rtl/sqroot_if.sv | 33 +++
 rtl/sqroot_step.sv | 33 +++
 rtl/sqroot_seq.sv | 120 ++++++++++++
 4 files changed

// File: rtl/sqroot_pkg.sv
// Shared types and width helpers for the iterative square-root unit.
// Optional feature macro: SQROOT_REM_EN (adds the floor-remainder output).
package sqroot_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CALC  = 2'd1,
    ROUND = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int NBITS_DEFAULT = 8;

  // Result carries one extra bit so round-to-nearest can reach 2^(nbits/2).
  function automatic int result_width(input int nbits);
    return nbits / 2 + 1;
  endfunction

  // Partial remainder never exceeds 2*root, plus headroom for the shifted-in digit pair.
  function automatic int rem_width(input int nbits);
    return nbits / 2 + 2;
  endfunction

  // Step counter runs nbits/2-1 down to 0.
  function automatic int step_cnt_width(input int nbits);
    return $clog2(nbits / 2);
  endfunction

endpackage

// File: rtl/sqroot_if.sv
// Operand/result handshake bundle for sqroot_seq.
// Optional feature macro: SQROOT_REM_EN (adds rem_out).
interface sqroot_if
  import sqroot_pkg::*;
#(
  parameter int NBITS = NBITS_DEFAULT
);
  localparam int RBITS = result_width(NBITS);

  logic             in_valid;
  logic             in_ready;
  logic [NBITS-1:0] arg;
  logic             roundup;
  logic             out_valid;
  logic             out_ready;
  logic [RBITS-1:0] sqroot;
`ifdef SQROOT_REM_EN
  logic [NBITS/2:0] rem_out;
`endif

`ifdef SQROOT_REM_EN
  modport master (output in_valid, arg, roundup, out_ready,
                  input  in_ready, out_valid, sqroot, rem_out);
  modport slave  (input  in_valid, arg, roundup, out_ready,
                  output in_ready, out_valid, sqroot, rem_out);
`else
  modport master (output in_valid, arg, roundup, out_ready,
                  input  in_ready, out_valid, sqroot);
  modport slave  (input  in_valid, arg, roundup, out_ready,
                  output in_ready, out_valid, sqroot);
`endif

endinterface

// File: rtl/sqroot_step.sv
// One digit step of the shift-and-subtract square root: brings in the next
// two operand bits and decides the next root bit.
module sqroot_step
  import sqroot_pkg::*;
#(
  parameter int NBITS = NBITS_DEFAULT
) (
  input  logic [NBITS/2+1:0] rem,
  input  logic [NBITS/2-1:0] root,
  input  logic [1:0]         bits,
  output logic [NBITS/2+1:0] rem_next,
  output logic [NBITS/2-1:0] root_next
);
  localparam int HALF = NBITS / 2;
  localparam int WREM = rem_width(NBITS);

  logic [WREM-1:0] shifted;
  logic [WREM-1:0] trial;

  // Top two remainder bits are zero before the shift, so truncation is lossless.
  always_comb begin
    shifted = WREM'({rem, bits});
    trial   = {root, 2'b01};
    if (shifted >= trial) begin
      rem_next  = shifted - trial;
      root_next = HALF'({root, 1'b1});
    end else begin
      rem_next  = shifted;
      root_next = HALF'({root, 1'b0});
    end
  end

endmodule

// File: rtl/sqroot_seq.sv
// Iterative NBITS-wide integer square root, one result bit per clock,
// floor or round-to-nearest, valid/ready on both sides.
// Optional feature macro: SQROOT_REM_EN (drives bus.rem_out with the floor remainder).
module sqroot_seq
  import sqroot_pkg::*;
#(
  parameter int NBITS = NBITS_DEFAULT
) (
  input  logic    clk,
  input  logic    rst,
  sqroot_if.slave bus
);
  localparam int HALF  = NBITS / 2;
  localparam int RBITS = result_width(NBITS);
  localparam int WREM  = rem_width(NBITS);
  localparam int CNT_W = step_cnt_width(NBITS);

  if ((NBITS % 2) != 0 || NBITS < 4) begin : g_bad_nbits
    $error("sqroot_seq: NBITS must be even and >= 4");
  end

  logic [1:0]       rst_pipe;
  logic             rst_int;
  state_t           state;
  logic [NBITS-1:0] arg_q;
  logic             roundup_q;
  logic [WREM-1:0]  rem_q;
  logic [HALF-1:0]  root_q;
  logic [CNT_W-1:0] cnt_q;
  logic             in_ready_q;
  logic             out_valid_q;
  logic [RBITS-1:0] sqroot_q;
  logic [WREM-1:0]  rem_next;
  logic [HALF-1:0]  root_next;
  logic             round_up;
`ifdef SQROOT_REM_EN
  logic [HALF:0]    rem_out_q;
`endif

  // Reset asserts immediately, releases two clocks after rst falls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rst_pipe <= 2'b11;
    else     rst_pipe <= {rst_pipe[0], 1'b0};
  end
  assign rst_int = rst_pipe[1];

  sqroot_step #(.NBITS(NBITS)) u_step (
    .rem       (rem_q),
    .root      (root_q),
    .bits      (arg_q[NBITS-1:NBITS-2]),
    .rem_next  (rem_next),
    .root_next (root_next)
  );

  // Floor remainder above root means the true root is past r+0.5.
  assign round_up = roundup_q && (rem_q > {2'b00, root_q});

  // Control FSM and datapath registers.
  always_ff @(posedge clk or posedge rst_int) begin
    if (rst_int) begin
      state       <= IDLE;
      arg_q       <= '0;
      roundup_q   <= 1'b0;
      rem_q       <= '0;
      root_q      <= '0;
      cnt_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      sqroot_q    <= '0;
`ifdef SQROOT_REM_EN
      rem_out_q   <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid && in_ready_q) begin
            arg_q      <= bus.arg;
            roundup_q  <= bus.roundup;
            rem_q      <= '0;
            root_q     <= '0;
            cnt_q      <= CNT_W'(HALF - 1);
            in_ready_q <= 1'b0;
            state      <= CALC;
          end
        end
        CALC: begin
          rem_q  <= rem_next;
          root_q <= root_next;
          arg_q  <= {arg_q[NBITS-3:0], 2'b00};
          if (cnt_q == '0) state <= ROUND;
          else             cnt_q <= cnt_q - CNT_W'(1);
        end
        ROUND: begin
          sqroot_q    <= {1'b0, root_q} + {{HALF{1'b0}}, round_up};
`ifdef SQROOT_REM_EN
          rem_out_q   <= rem_q[HALF:0];
`endif
          out_valid_q <= 1'b1;
          state       <= DONE;
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.sqroot    = sqroot_q;
`ifdef SQROOT_REM_EN
  assign bus.rem_out   = rem_out_q;
`endif

endmodule
